h8_mem_arbiter: RTL and testbench
=================================

# h8_mem_arbiter

Two-port-to-one memory arbiter that lets the `h8_core` instruction fetch port and data port share a single `ram_1rw` instance, giving a unified von Neumann memory. It accepts one request per cycle toward the RAM and picks a winner when both ports request together. It routes the one-cycle-latency RAM read data back to the port that issued the read, and exposes per-port stall counters for performance analysis.

## Interface
Parameters:
- `ADDR_W`, 8: address width.
- `DATA_W`, 8: data width.
- `CNT_W`, 16: stall counter width.
- `FIXED_PRIO`, 0: 0 = round-robin arbitration; 1 = data port always wins.

Ports:
- `i_clk`  in  1  clock; the only clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_imem_req_addr`  in  ADDR_W  instruction read address.
- `i_imem_req_valid`  in  1  instruction read request.
- `o_imem_req_ready`  out  1  instruction request accepted this cycle.
- `o_imem_rsp_valid`  out  1  instruction read data valid.
- `o_imem_rsp_data`  out  DATA_W  instruction read data.
- `i_dmem_req_addr`  in  ADDR_W  data address.
- `i_dmem_req_data`  in  DATA_W  write data.
- `i_dmem_req_write`  in  1  1 = write, 0 = read.
- `i_dmem_req_valid`  in  1  data request.
- `o_dmem_req_ready`  out  1  data request accepted this cycle.
- `o_dmem_rsp_valid`  out  1  data read data valid.
- `o_dmem_rsp_data`  out  DATA_W  data read data.
- `o_ram_req_addr`  out  ADDR_W  to `ram_1rw`.
- `o_ram_req_data`  out  DATA_W  to `ram_1rw`.
- `o_ram_req_write`  out  1  to `ram_1rw`.
- `o_ram_req_valid`  out  1  to `ram_1rw`.
- `i_ram_rsp_data`  in  DATA_W  from `ram_1rw`; valid the cycle after an accepted read.
- `o_imem_stall_count`  out  CNT_W  cycles the instruction port had valid without ready.
- `o_dmem_stall_count`  out  CNT_W  cycles the data port had valid without ready.

## Operation

**Grant.** Grant is combinational from the current-cycle valids and the registered `last_grant` bit (0 = imem, 1 = dmem).
- Only one port valid: that port is granted.
- Both valid with `FIXED_PRIO` = 1: dmem is granted.
- Both valid with `FIXED_PRIO` = 0: the port that was not `last_grant` is granted.
- `last_grant` updates only on a cycle with an actual grant. Its reset value is 0, so dmem wins the first contention.

**Handshake.**
- `o_X_req_ready` = grant to port X. A request completes when valid && ready.
- A requester holds addr, data and write stable while valid && !ready.
- Neither port is ever starved in round-robin mode; the maximum wait is 1 cycle. In fixed mode imem may starve indefinitely.

**RAM drive.**
- `o_ram_req_valid` = OR of the valids.
- addr, data and write are muxed from the granted port.
- For an imem grant: write = 0 and data = 0.
- With no grant: addr, data and write = 0.

**Response routing.**
- Registered `rsp_pend` (1 bit) and `rsp_sel` (1 bit) are set on the grant cycle. `rsp_pend` = granted && !write.
- Next cycle, `o_<rsp_sel>_rsp_valid` = `rsp_pend`, and `o_<rsp_sel>_rsp_data` = `i_ram_rsp_data`.
- The non-selected port has rsp_valid = 0 and rsp_data = 0.
- Writes produce no response; a write is complete on acceptance.

**Stall counters.**
- Increment when valid && !ready.
- Saturate at all-ones, with no wrap.
- Clear only on reset.

## Timing
- Request acceptance has zero added latency: the grant and RAM request happen in the same cycle.
- Read data returns exactly 1 cycle after acceptance, the same as direct `ram_1rw` use.
- Back-to-back accepted reads from alternating ports return in order, one per cycle, with no bubbles.
- Reset values:
  - All ready, rsp_valid, rsp_data and ram_req_* outputs = 0. While `i_rst` is high, ready and `o_ram_req_valid` are forced to 0.
  - `last_grant` = 0.
  - `rsp_pend` = 0.
  - Stall counters = 0.
- Reset asserted the cycle after a read was accepted: the response is dropped, and rsp_valid stays 0 on that and all later reset cycles.
- A write to address A followed next cycle by a read of A from the other port returns the new data. Ordering is the `ram_1rw` write-then-read order.
- Simultaneous events:
  - Stall counters increment in the same cycle as a grant to the other port.
  - An rsp_valid for one port can coincide with a new grant to either port.

## Test plan
- **Single port.** After reset, imem reads addr 0x10 holding 0x3C, with dmem idle. Required: ready the same cycle, then `o_imem_rsp_valid` = 1 and data = 0x3C the next cycle. `o_imem_stall_count` = 0.
- **First contention.** Both valid on the first cycle after reset. Required: dmem read of 0x20 is granted first; imem is granted the next cycle; responses return on consecutive cycles to the correct ports. `o_imem_stall_count` = 1.
- **Round-robin fairness.** Both held valid for 10 cycles with `FIXED_PRIO` = 0. Required: grants alternate d, i, d, i, …, 5 each. Each stall counter = 5 minus the final-cycle effect; check exactly against the model.
- **Fixed priority.** Both held valid for 8 cycles with `FIXED_PRIO` = 1. Required: 8 dmem grants, 0 imem grants, `o_imem_stall_count` = 8.
- **Write then read.** dmem writes 0xA5 to 0x40, then imem reads 0x40 on the next cycle. Required: the write produces no rsp_valid; the imem response is 0xA5.
- **Saturation and reset.**
  - With `CNT_W` = 4, stall imem for 20 cycles. Required: the counter holds at 15.
  - Assert reset the cycle after an accepted read. Required: no rsp_valid and counters = 0.

Source files
------------

// File: rtl/h8_mem_arbiter.sv
// h8_mem_arbiter: shares one single-port ram_1rw between the h8_core
// instruction-fetch port and data port. One request per cycle reaches the
// RAM. Read data comes back one cycle later and is steered to the issuing
// port. Each port has a saturating stall counter.
module h8_mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_imem_req_addr,
  input  logic              i_imem_req_valid,
  output logic              o_imem_req_ready,
  output logic              o_imem_rsp_valid,
  output logic [DATA_W-1:0] o_imem_rsp_data,
  input  logic [ADDR_W-1:0] i_dmem_req_addr,
  input  logic [DATA_W-1:0] i_dmem_req_data,
  input  logic              i_dmem_req_write,
  input  logic              i_dmem_req_valid,
  output logic              o_dmem_req_ready,
  output logic              o_dmem_rsp_valid,
  output logic [DATA_W-1:0] o_dmem_rsp_data,
  output logic [ADDR_W-1:0] o_ram_req_addr,
  output logic [DATA_W-1:0] o_ram_req_data,
  output logic              o_ram_req_write,
  output logic              o_ram_req_valid,
  input  logic [DATA_W-1:0] i_ram_rsp_data,
  output logic [CNT_W-1:0]  o_imem_stall_count,
  output logic [CNT_W-1:0]  o_dmem_stall_count
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              write;
  } ram_req_t;

  logic     last_grant;  // 0 = imem, 1 = dmem
  logic     rsp_pend;
  logic     rsp_sel;     // 0 = imem, 1 = dmem
  logic     gnt_i, gnt_d;
  ram_req_t ram_req;

  // Grant: a lone requester wins. On contention, dmem wins in fixed mode.
  // In round-robin mode the port that lost last time wins. Reset masks all grants.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (!i_rst) begin
      if (i_imem_req_valid && i_dmem_req_valid) begin
        if (FIXED_PRIO != 0 || !last_grant) gnt_d = 1'b1;
        else                                gnt_i = 1'b1;
      end else begin
        gnt_i = i_imem_req_valid;
        gnt_d = i_dmem_req_valid;
      end
    end
  end

  // RAM request mux. An instruction fetch is always a read with zero data.
  always_comb begin
    ram_req = '0;
    if (gnt_d) begin
      ram_req.addr  = i_dmem_req_addr;
      ram_req.data  = i_dmem_req_data;
      ram_req.write = i_dmem_req_write;
    end else if (gnt_i) begin
      ram_req.addr = i_imem_req_addr;
    end
  end

  assign o_imem_req_ready = gnt_i;
  assign o_dmem_req_ready = gnt_d;
  assign o_ram_req_valid  = !i_rst && (i_imem_req_valid || i_dmem_req_valid);
  assign o_ram_req_addr   = ram_req.addr;
  assign o_ram_req_data   = ram_req.data;
  assign o_ram_req_write  = ram_req.write;

  // Arbitration history and the one-deep read-response tag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_grant <= 1'b0;
      rsp_pend   <= 1'b0;
      rsp_sel    <= 1'b0;
    end else begin
      rsp_pend <= (gnt_i || gnt_d) && !ram_req.write;
      if (gnt_i || gnt_d) begin
        last_grant <= gnt_d;
        rsp_sel    <= gnt_d;
      end
    end
  end

  // Steer RAM read data to the tagged port. The combinational reset gate
  // drops a response that lands on a reset cycle.
  always_comb begin
    o_imem_rsp_valid = !i_rst && rsp_pend && !rsp_sel;
    o_dmem_rsp_valid = !i_rst && rsp_pend && rsp_sel;
    o_imem_rsp_data  = o_imem_rsp_valid ? i_ram_rsp_data : '0;
    o_dmem_rsp_data  = o_dmem_rsp_valid ? i_ram_rsp_data : '0;
  end

  // Instruction-port stall counter: saturates, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_imem_stall_count <= '0;
    else if (i_imem_req_valid && !gnt_i && o_imem_stall_count != '1)
      o_imem_stall_count <= o_imem_stall_count + CNT_W'(1);
  end

  // Data-port stall counter: saturates, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_dmem_stall_count <= '0;
    else if (i_dmem_req_valid && !gnt_d && o_dmem_stall_count != '1)
      o_dmem_stall_count <= o_dmem_stall_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_h8_mem_arbiter.sv
// Bench for h8_mem_arbiter. Instance 0 uses round-robin arbitration with
// 16-bit counters. Instance 1 uses fixed priority with 4-bit counters.
// Each instance has its own RAM and a reference model.
module tb_h8_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Per-instance request drive.
  logic       iv[2];
  logic [7:0] ia[2];
  logic       dv[2];
  logic [7:0] da[2];
  logic [7:0] dd[2];
  logic       dw[2];
  logic [7:0] rsp[2];

  // Per-instance observed outputs.
  logic        i_rdy[2], i_rv[2], d_rdy[2], d_rv[2], rv[2], rw[2];
  logic [7:0]  i_rd[2], d_rd[2], ra[2], rd[2];
  logic [15:0] i_sc[2], d_sc[2];

  logic        a_irdy, a_irv, a_drdy, a_drv, a_rv, a_rw;
  logic [7:0]  a_ird, a_drd, a_ra, a_rd;
  logic [15:0] a_isc, a_dsc;
  logic        b_irdy, b_irv, b_drdy, b_drv, b_rv, b_rw;
  logic [7:0]  b_ird, b_drd, b_ra, b_rd;
  logic [3:0]  b_isc, b_dsc;

  h8_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .CNT_W(16), .FIXED_PRIO(0)) u_rr (
    .i_clk(clk), .i_rst(rst),
    .i_imem_req_addr(ia[0]), .i_imem_req_valid(iv[0]), .o_imem_req_ready(a_irdy),
    .o_imem_rsp_valid(a_irv), .o_imem_rsp_data(a_ird),
    .i_dmem_req_addr(da[0]), .i_dmem_req_data(dd[0]), .i_dmem_req_write(dw[0]),
    .i_dmem_req_valid(dv[0]), .o_dmem_req_ready(a_drdy),
    .o_dmem_rsp_valid(a_drv), .o_dmem_rsp_data(a_drd),
    .o_ram_req_addr(a_ra), .o_ram_req_data(a_rd), .o_ram_req_write(a_rw),
    .o_ram_req_valid(a_rv), .i_ram_rsp_data(rsp[0]),
    .o_imem_stall_count(a_isc), .o_dmem_stall_count(a_dsc));

  h8_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .CNT_W(4), .FIXED_PRIO(1)) u_fx (
    .i_clk(clk), .i_rst(rst),
    .i_imem_req_addr(ia[1]), .i_imem_req_valid(iv[1]), .o_imem_req_ready(b_irdy),
    .o_imem_rsp_valid(b_irv), .o_imem_rsp_data(b_ird),
    .i_dmem_req_addr(da[1]), .i_dmem_req_data(dd[1]), .i_dmem_req_write(dw[1]),
    .i_dmem_req_valid(dv[1]), .o_dmem_req_ready(b_drdy),
    .o_dmem_rsp_valid(b_drv), .o_dmem_rsp_data(b_drd),
    .o_ram_req_addr(b_ra), .o_ram_req_data(b_rd), .o_ram_req_write(b_rw),
    .o_ram_req_valid(b_rv), .i_ram_rsp_data(rsp[1]),
    .o_imem_stall_count(b_isc), .o_dmem_stall_count(b_dsc));

  always_comb begin
    i_rdy[0] = a_irdy; i_rv[0] = a_irv; i_rd[0] = a_ird;
    d_rdy[0] = a_drdy; d_rv[0] = a_drv; d_rd[0] = a_drd;
    rv[0] = a_rv; ra[0] = a_ra; rd[0] = a_rd; rw[0] = a_rw;
    i_sc[0] = a_isc; d_sc[0] = a_dsc;
    i_rdy[1] = b_irdy; i_rv[1] = b_irv; i_rd[1] = b_ird;
    d_rdy[1] = b_drdy; d_rv[1] = b_drv; d_rd[1] = b_drd;
    rv[1] = b_rv; ra[1] = b_ra; rd[1] = b_rd; rw[1] = b_rw;
    i_sc[1] = {12'd0, b_isc}; d_sc[1] = {12'd0, b_dsc};
  end

  // ram_1rw stand-ins: write on an accepted write, and return read data one cycle later.
  logic [7:0] mem[2][256];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (rv[k]) begin
        if (rw[k]) mem[k][ra[k]] <= rd[k];
        else       rsp[k] <= mem[k][ra[k]];
      end
  end

  // Reference model state.
  logic [7:0] shadow[2][256];
  bit         lg[2];           // which port was granted last: 0 imem, 1 dmem
  bit         pv[2], ps[2];    // pending read response and its port
  logic [7:0] pdat[2];
  int         sc_i[2], sc_d[2];
  bit         hold_i[2], hold_d[2];
  int         gi[2], gd[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock. At the falling edge, compare the DUT with the model and advance the model.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bit         w_i, w_d, e_iv, e_dv, e_rw;
      logic [7:0] e_ra, e_rd;
      int         lim;
      lim  = (k == 0) ? 65535 : 15;
      e_iv = !rst && pv[k] && !ps[k];
      e_dv = !rst && pv[k] && ps[k];
      w_i = 0; w_d = 0;
      if (!rst) begin
        if (iv[k] && dv[k]) begin
          // contention: fixed instance favours dmem; otherwise the previous loser wins
          if (k == 1) w_d = 1;
          else if (lg[k]) w_i = 1;
          else w_d = 1;
        end else begin
          w_i = iv[k];
          w_d = dv[k];
        end
      end
      e_ra = w_d ? da[k] : (w_i ? ia[k] : 8'h00);
      e_rd = w_d ? dd[k] : 8'h00;
      e_rw = w_d ? dw[k] : 1'b0;
      chk($sformatf("imem_ready[%0d]", k), i_rdy[k], w_i);
      chk($sformatf("dmem_ready[%0d]", k), d_rdy[k], w_d);
      chk($sformatf("ram_valid[%0d]", k), rv[k], !rst && (iv[k] || dv[k]));
      chk($sformatf("ram_addr[%0d]", k), ra[k], e_ra);
      chk($sformatf("ram_data[%0d]", k), rd[k], e_rd);
      chk($sformatf("ram_write[%0d]", k), rw[k], e_rw);
      chk($sformatf("imem_rsp_valid[%0d]", k), i_rv[k], e_iv);
      chk($sformatf("imem_rsp_data[%0d]", k), i_rd[k], e_iv ? pdat[k] : 8'h00);
      chk($sformatf("dmem_rsp_valid[%0d]", k), d_rv[k], e_dv);
      chk($sformatf("dmem_rsp_data[%0d]", k), d_rd[k], e_dv ? pdat[k] : 8'h00);
      chk($sformatf("imem_stall[%0d]", k), i_sc[k], sc_i[k]);
      chk($sformatf("dmem_stall[%0d]", k), d_sc[k], sc_d[k]);
      if (rst) begin
        lg[k] = 0; pv[k] = 0; sc_i[k] = 0; sc_d[k] = 0;
      end else begin
        if (iv[k] && !w_i && sc_i[k] < lim) sc_i[k]++;
        if (dv[k] && !w_d && sc_d[k] < lim) sc_d[k]++;
        pv[k] = w_i || (w_d && !dw[k]);
        if (w_i) begin
          lg[k] = 0; ps[k] = 0; pdat[k] = shadow[k][ia[k]];
        end
        if (w_d) begin
          lg[k] = 1; ps[k] = 1;
          if (dw[k]) shadow[k][da[k]] = dd[k];
          else       pdat[k] = shadow[k][da[k]];
        end
      end
      gi[k] += int'(i_rdy[k]);
      gd[k] += int'(d_rdy[k]);
      // A requester keeps its request stable until the DUT accepts it.
      hold_i[k] = iv[k] && !i_rdy[k] && !rst;
      hold_d[k] = dv[k] && !d_rdy[k] && !rst;
    end
    @(posedge clk);
    #1;
  endtask

  // Offer a new request to both instances. A port that is still stalled keeps its old request.
  task automatic req(input bit r, input bit niv, input logic [7:0] nia, input bit ndv,
                     input logic [7:0] nda, input logic [7:0] ndd, input bit ndw);
    rst = r;
    for (int k = 0; k < 2; k++) begin
      if (!hold_i[k]) begin iv[k] = niv; ia[k] = nia; end
      if (!hold_d[k]) begin dv[k] = ndv; da[k] = nda; dd[k] = ndd; dw[k] = ndw; end
    end
    step();
  endtask

  task automatic idle(input bit r);
    req(r, 0, 8'h00, 0, 8'h00, 8'h00, 0);
  endtask

  task automatic clr_counts();
    for (int k = 0; k < 2; k++) begin gi[k] = 0; gd[k] = 0; end
  endtask

  initial begin
    logic [7:0] v;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 0; ia[k] = 0; dv[k] = 0; da[k] = 0; dd[k] = 0; dw[k] = 0;
      lg[k] = 0; pv[k] = 0; ps[k] = 0; pdat[k] = 0; sc_i[k] = 0; sc_d[k] = 0;
      hold_i[k] = 0; hold_d[k] = 0; gi[k] = 0; gd[k] = 0;
      for (int a = 0; a < 256; a++) begin
        v = 8'($urandom);
        if (a == 8'h10) v = 8'h3C;
        if (a == 8'h20) v = 8'h5A;
        if (a == 8'h30) v = 8'hC3;
        mem[k][a] = v;
        shadow[k][a] = v;
      end
    end
    #1;
    idle(1); idle(1);

    // single port read
    req(0, 1, 8'h10, 0, 8'h00, 8'h00, 0);
    chk("single_rsp_valid", i_rv[0], 1);
    chk("single_rsp_data", i_rd[0], 8'h3C);
    idle(0);
    chk("single_istall", i_sc[0], 0);

    // first contention after reset: dmem first, then imem
    idle(1);
    req(0, 1, 8'h30, 1, 8'h20, 8'h00, 0);
    chk("cont_d_rsp_valid", d_rv[0], 1);
    chk("cont_d_rsp_data", d_rd[0], 8'h5A);
    idle(0);
    chk("cont_i_rsp_valid", i_rv[0], 1);
    chk("cont_i_rsp_data", i_rd[0], 8'hC3);
    chk("cont_istall", i_sc[0], 1);
    idle(0);

    // round-robin fairness: 10 cycles of contention
    idle(1);
    clr_counts();
    repeat (10) req(0, 1, 8'($urandom), 1, 8'($urandom), 8'h00, 0);
    chk("rr_dmem_grants", gd[0], 5);
    chk("rr_imem_grants", gi[0], 5);
    chk("rr_fixed_dmem_grants", gd[1], 10);

    // fixed priority: 8 cycles of contention
    idle(1);
    clr_counts();
    repeat (8) req(0, 1, 8'($urandom), 1, 8'($urandom), 8'h00, 0);
    chk("fx_dmem_grants", gd[1], 8);
    chk("fx_imem_grants", gi[1], 0);
    chk("fx_istall", i_sc[1], 8);

    // write then read of the same address from the other port
    idle(1);
    req(0, 0, 8'h00, 1, 8'h40, 8'hA5, 1);
    chk("wr_no_rsp_d", d_rv[0], 0);
    chk("wr_no_rsp_i", i_rv[0], 0);
    req(0, 1, 8'h40, 0, 8'h00, 8'h00, 0);
    chk("wr_rd_valid_rr", i_rv[0], 1);
    chk("wr_rd_data_rr", i_rd[0], 8'hA5);
    chk("wr_rd_data_fx", i_rd[1], 8'hA5);
    idle(0);

    // imem stall counter saturation on the 4-bit instance
    idle(1);
    repeat (20) req(0, 1, 8'h11, 1, 8'h22, 8'h00, 0);
    chk("sat_istall", i_sc[1], 15);

    // reset the cycle after an accepted read
    idle(1);
    req(0, 1, 8'h10, 0, 8'h00, 8'h00, 0);
    idle(1);
    chk("rst_drop_rsp", i_rv[0], 0);
    chk("rst_istall", i_sc[1], 0);
    chk("rst_dstall", d_sc[0], 0);
    idle(0);

    // randomized traffic with occasional resets
    for (int n = 0; n < 400; n++)
      req($urandom_range(0, 39) == 0,
          $urandom_range(0, 9) < 6, 8'($urandom_range(0, 15)),
          $urandom_range(0, 9) < 6, 8'($urandom_range(0, 15)), 8'($urandom),
          $urandom_range(0, 2) == 0);
    repeat (3) idle(0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
